// File: rtl/hdc_pkg.sv
// -----------------------------------------------------------------------------
// hdc_pkg
// Shared definitions for the HDC stream classifier:
//   - controller state encoding
//   - item-memory seed and the xorshift32 mixing function
//   - item_hv(): reference character -> hypervector mapping. Chunk j of the
//     vector (bits 32*j+31 : 32*j) is xorshift32(seed ^ {j, char}), where the
//     character occupies the low char_w bits of the key.
// No ports (package).
// -----------------------------------------------------------------------------
package hdc_pkg;

    localparam logic [31:0] ITEM_SEED = 32'hACE1_2024;

    // Widest hypervector the reference function can produce.
    localparam int HV_MAX = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_BUNDLE = 3'd2,
        ST_SEARCH = 3'd3,
        ST_DONE   = 3'd4
    } hdc_state_e;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] v;
        v = x;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    function automatic logic [31:0] item_chunk(input logic [31:0] ch, input int j, input int char_w);
        logic [31:0] key;
        key = (32'(j) << char_w) | ch;
        return xorshift32(ITEM_SEED ^ key);
    endfunction

    // ch must be zero-extended to 32 bits by the caller; bits above dim are 0.
    function automatic logic [HV_MAX-1:0] item_hv(input logic [31:0] ch, input int dim,
                                                  input int char_w = 8);
        logic [HV_MAX-1:0] hv;
        hv = '0;
        for (int j = 0; j < HV_MAX / 32; j++) begin
            if (j < dim / 32) begin
                hv[j*32 +: 32] = item_chunk(ch, j, char_w);
            end
        end
        return hv;
    endfunction

endpackage

// File: rtl/hdc_stream_classifier_if.sv
// -----------------------------------------------------------------------------
// hdc_stream_classifier_if
// Bundles the character stream, prototype write port and result handshake of
// the HDC classifier.
//   char_valid/char_ready/char_data/char_last : message stream, one char/cycle
//   proto_we/proto_addr/proto_data            : prototype load (idle only)
//   res_valid/res_ready                       : result handshake
//   res_class/res_dist/res_overflow           : result payload
//   res_inconclusive                          : tie flag, only when the macro
//                                               HDC_TIE_DETECT_EN is defined
// Modports: master (stimulus side), slave (classifier side).
// -----------------------------------------------------------------------------
interface hdc_stream_classifier_if #(
    parameter int HV_DIM  = 1024,
    parameter int CHAR_W  = 8,
    parameter int CLASS_W = 1,
    parameter int DIST_W  = 11
);
    logic                char_valid;
    logic                char_ready;
    logic [CHAR_W-1:0]   char_data;
    logic                char_last;
    logic                proto_we;
    logic [CLASS_W-1:0]  proto_addr;
    logic [HV_DIM-1:0]   proto_data;
    logic                res_valid;
    logic                res_ready;
    logic [CLASS_W-1:0]  res_class;
    logic [DIST_W-1:0]   res_dist;
    logic                res_overflow;
`ifdef HDC_TIE_DETECT_EN
    logic                res_inconclusive;
`endif

    modport master (
`ifdef HDC_TIE_DETECT_EN
        input  res_inconclusive,
`endif
        output char_valid, char_data, char_last, proto_we, proto_addr, proto_data, res_ready,
        input  char_ready, res_valid, res_class, res_dist, res_overflow
    );

    modport slave (
`ifdef HDC_TIE_DETECT_EN
        output res_inconclusive,
`endif
        input  char_valid, char_data, char_last, proto_we, proto_addr, proto_data, res_ready,
        output char_ready, res_valid, res_class, res_dist, res_overflow
    );

endinterface

// File: rtl/hdc_stream_classifier_item_memory.sv
// -----------------------------------------------------------------------------
// hdc_item_memory
// Combinational item memory: maps a character code to its item hypervector
// using the package reference mapping, so hardware and model cannot diverge.
//   char_i : character code
//   hv_o   : item hypervector (HV_DIM bits)
// -----------------------------------------------------------------------------
module hdc_item_memory
    import hdc_pkg::*;
#(
    parameter int HV_DIM = 1024,
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] char_i,
    output logic [HV_DIM-1:0] hv_o
);

    // Character to item vector lookup
    always_comb begin
        hv_o = HV_DIM'(item_hv(32'(char_i), HV_DIM, CHAR_W));
    end

endmodule

// File: rtl/hdc_stream_classifier.sv
// -----------------------------------------------------------------------------
// hdc_stream_classifier
// Hyperdimensional-computing text classifier. Characters stream in, each is
// mapped to an item hypervector, N-grams are bound by rotate/XOR over a sliding
// window, bundled by per-bit majority into a query, and the query is compared
// against NUM_CLASSES stored prototypes by Hamming distance (one per cycle).
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (clears prototypes as well)
//   bus   : hdc_stream_classifier_if.slave (stream, prototype load, result)
// Optional feature: define HDC_TIE_DETECT_EN to add res_inconclusive; a tie on
// the winning distance then reports class 0 with res_inconclusive=1.
// -----------------------------------------------------------------------------
module hdc_stream_classifier
    import hdc_pkg::*;
#(
    parameter  int HV_DIM      = 1024,
    parameter  int CHAR_W      = 8,
    parameter  int NGRAM       = 3,
    parameter  int NUM_CLASSES = 2,
    parameter  int MAX_LEN     = 160,
    localparam int CLASS_W     = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int CNT_W       = $clog2(MAX_LEN + 1),
    localparam int DIST_W      = $clog2(HV_DIM + 1),
    localparam int FILL_W      = $clog2(NGRAM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    hdc_stream_classifier_if.slave  bus
);

    hdc_state_e          state_q;
    logic [HV_DIM-1:0]   win_q [NGRAM];
    logic [FILL_W-1:0]   fill_q;
    logic [CNT_W-1:0]    char_cnt_q;
    logic [CNT_W-1:0]    ngram_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_q [HV_DIM];
    logic                overflow_q;
    logic [HV_DIM-1:0]   query_q;
    logic [HV_DIM-1:0]   proto_q [NUM_CLASSES];
    logic [CLASS_W-1:0]  idx_q;
    logic [DIST_W-1:0]   best_dist_q;
    logic [CLASS_W-1:0]  best_class_q;
    logic                res_valid_q;
    logic [CLASS_W-1:0]  res_class_q;
    logic [DIST_W-1:0]   res_dist_q;
    logic                res_overflow_q;

    logic                char_ready_s;
    logic                accept_s;
    logic                count_s;
    logic                ngram_ready_s;
    logic [HV_DIM-1:0]   item_s;
    logic [HV_DIM-1:0]   win_next_s [NGRAM];
    logic [HV_DIM-1:0]   ngram_s;
    logic [HV_DIM-1:0]   query_s;
    logic [DIST_W-1:0]   dist_s;
    logic                better_s;
    logic                last_idx_s;
    logic [DIST_W-1:0]   best_dist_next_s;
    logic [CLASS_W-1:0]  best_class_next_s;
    logic [CLASS_W-1:0]  final_class_s;

    function automatic logic [HV_DIM-1:0] rotl(input logic [HV_DIM-1:0] v, input int sh);
        int s;
        s = sh % HV_DIM;
        if (s == 0) begin
            return v;
        end else begin
            return (v << s) | (v >> (HV_DIM - s));
        end
    endfunction

    function automatic logic [DIST_W-1:0] popcount(input logic [HV_DIM-1:0] v);
        logic [DIST_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < HV_DIM; k++) begin
            acc = acc + DIST_W'(v[k]);
        end
        return acc;
    endfunction

    hdc_item_memory #(
        .HV_DIM (HV_DIM),
        .CHAR_W (CHAR_W)
    ) u_item_memory (
        .char_i (bus.char_data),
        .hv_o   (item_s)
    );

    // Stream acceptance; forced low while reset is asserted
    always_comb begin
        char_ready_s  = ~reset & ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
        accept_s      = bus.char_valid & char_ready_s;
        count_s       = (32'(char_cnt_q) < MAX_LEN);
        ngram_ready_s = (32'(fill_q) >= NGRAM - 1);
    end

    // Window after shifting in the current item; slot 0 is the oldest
    always_comb begin
        win_next_s = win_q;
        for (int i = 0; i < NGRAM - 1; i++) begin
            win_next_s[i] = win_q[i + 1];
        end
        win_next_s[NGRAM-1] = item_s;
    end

    // N-gram binding: older characters are rotated further
    always_comb begin
        ngram_s = '0;
        for (int i = 0; i < NGRAM; i++) begin
            ngram_s = ngram_s ^ rotl(win_next_s[i], NGRAM - 1 - i);
        end
    end

    // Majority bundling; an empty bundle yields all zeros because 0 > 0 fails
    always_comb begin
        query_s = '0;
        for (int k = 0; k < HV_DIM; k++) begin
            query_s[k] = ({bit_cnt_q[k], 1'b0} > {1'b0, ngram_cnt_q});
        end
    end

    // Distance of the class under scan and the running best
    always_comb begin
        dist_s     = popcount(query_q ^ proto_q[idx_q]);
        last_idx_s = (idx_q == CLASS_W'(NUM_CLASSES - 1));
        if ((idx_q == '0) || (dist_s < best_dist_q)) begin
            better_s = 1'b1;
        end else begin
            better_s = 1'b0;
        end
        if (better_s) begin
            best_dist_next_s  = dist_s;
            best_class_next_s = idx_q;
        end else begin
            best_dist_next_s  = best_dist_q;
            best_class_next_s = best_class_q;
        end
    end

`ifdef HDC_TIE_DETECT_EN
    logic tie_q;
    logic tie_next_s;
    logic res_incon_q;

    // A later class matching the best distance marks the result as a tie
    always_comb begin
        if (better_s) begin
            tie_next_s = 1'b0;
        end else if (dist_s == best_dist_q) begin
            tie_next_s = 1'b1;
        end else begin
            tie_next_s = tie_q;
        end
        if (tie_next_s) begin
            final_class_s = '0;
        end else begin
            final_class_s = best_class_next_s;
        end
    end

    // Tie flag tracking over the prototype scan
    always_ff @(posedge clk) begin
        if (reset) begin
            tie_q       <= 1'b0;
            res_incon_q <= 1'b0;
        end else if (state_q == ST_BUNDLE) begin
            tie_q <= 1'b0;
        end else if (state_q == ST_SEARCH) begin
            tie_q <= tie_next_s;
            if (last_idx_s) begin
                res_incon_q <= tie_next_s;
            end
        end else if ((state_q == ST_DONE) && bus.res_ready) begin
            tie_q       <= 1'b0;
            res_incon_q <= 1'b0;
        end
    end

    assign bus.res_inconclusive = res_incon_q;
`else
    // Without tie detection the lowest index wins outright
    always_comb begin
        final_class_s = best_class_next_s;
    end
`endif

    // Prototype store: writable only while idle, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_q <= '{default: '0};
        end else if (bus.proto_we && (state_q == ST_IDLE) &&
                     (32'(bus.proto_addr) < NUM_CLASSES)) begin
            proto_q[bus.proto_addr] <= bus.proto_data;
        end
    end

    // Controller: accumulate, bundle, scan prototypes, present result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            win_q          <= '{default: '0};
            fill_q         <= '0;
            char_cnt_q     <= '0;
            ngram_cnt_q    <= '0;
            bit_cnt_q      <= '{default: '0};
            overflow_q     <= 1'b0;
            query_q        <= '0;
            idx_q          <= '0;
            best_dist_q    <= '0;
            best_class_q   <= '0;
            res_valid_q    <= 1'b0;
            res_class_q    <= '0;
            res_dist_q     <= '0;
            res_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept_s) begin
                        if (count_s) begin
                            char_cnt_q <= char_cnt_q + CNT_W'(1);
                            win_q      <= win_next_s;
                            if (32'(fill_q) < NGRAM) begin
                                fill_q <= fill_q + FILL_W'(1);
                            end
                            if (ngram_ready_s) begin
                                ngram_cnt_q <= ngram_cnt_q + CNT_W'(1);
                                for (int k = 0; k < HV_DIM; k++) begin
                                    bit_cnt_q[k] <= bit_cnt_q[k] + CNT_W'(ngram_s[k]);
                                end
                            end
                        end else begin
                            // Past MAX_LEN: consume but do not count
                            overflow_q <= 1'b1;
                        end
                        state_q <= bus.char_last ? ST_BUNDLE : ST_ACCUM;
                    end
                end
                ST_BUNDLE: begin
                    query_q <= query_s;
                    idx_q   <= '0;
                    state_q <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    best_dist_q  <= best_dist_next_s;
                    best_class_q <= best_class_next_s;
                    idx_q        <= idx_q + CLASS_W'(1);
                    if (last_idx_s) begin
                        state_q        <= ST_DONE;
                        res_valid_q    <= 1'b1;
                        res_class_q    <= final_class_s;
                        res_dist_q     <= best_dist_next_s;
                        res_overflow_q <= overflow_q;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state_q        <= ST_IDLE;
                        win_q          <= '{default: '0};
                        fill_q         <= '0;
                        char_cnt_q     <= '0;
                        ngram_cnt_q    <= '0;
                        bit_cnt_q      <= '{default: '0};
                        overflow_q     <= 1'b0;
                        query_q        <= '0;
                        idx_q          <= '0;
                        best_dist_q    <= '0;
                        best_class_q   <= '0;
                        res_valid_q    <= 1'b0;
                        res_class_q    <= '0;
                        res_dist_q     <= '0;
                        res_overflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.char_ready   = char_ready_s;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_class    = res_class_q;
    assign bus.res_dist     = res_dist_q;
    assign bus.res_overflow = res_overflow_q;

endmodule
